// File: rtl/adc_cap_pkg.sv
// Shared types and field positions for the ADC capture controller.
package adc_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam int unsigned WR_DATA_W     = 16;
  localparam int unsigned TRIG_MARK_BIT = 15;

endpackage

// File: rtl/trig_detect.sv
// Sample history register plus level-crossing compare.
// Produces a combinational one-cycle hit on the crossing sample.
module trig_detect #(
  parameter int unsigned ADC_W = 12
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             hist_clr,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  input  logic [ADC_W-1:0] trig_level,
  input  logic             trig_rise,
  output logic             trig_hit_c
);

  logic [ADC_W-1:0] sample_q;
  logic             hist_vld;
  logic             below_prev_c;
  logic             below_now_c;

  // A clear wins over a same-cycle sample so the arm-cycle sample is not history.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      sample_q <= '0;
      hist_vld <= 1'b0;
    end else if (hist_clr) begin
      hist_vld <= 1'b0;
    end else if (adc_valid) begin
      sample_q <= adc_data;
      hist_vld <= 1'b1;
    end
  end

  always_comb begin
    below_prev_c = (sample_q < trig_level);
    below_now_c  = (adc_data < trig_level);
    trig_hit_c   = 1'b0;
    if (adc_valid && hist_vld) begin
      trig_hit_c = trig_rise ? (below_prev_c && !below_now_c)
                             : (!below_prev_c && below_now_c);
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered ADC acquisition front end streaming a decimated, fixed-length
// record into the SDRAM write FIFO.
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int unsigned ADC_W = 12,
  parameter int unsigned LEN_W = 24,
  parameter int unsigned DEC_W = 8
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             sdram_init_done,
  input  logic             arm,
  input  logic             abort,
  input  logic             force_trig,
  input  logic [ADC_W-1:0] trig_level,
  input  logic             trig_rise,
  input  logic [LEN_W-1:0] record_len,
  input  logic [DEC_W-1:0] decim,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic             wr_en,
  output logic [15:0]      wr_data,
  output logic             busy,
  output logic             triggered,
  output logic             done,
  output logic [LEN_W-1:0] wr_cnt
);

  cap_state_e               state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [DEC_W-1:0]         decim_q, decim_d;
  logic [DEC_W-1:0]         dcnt_q, dcnt_d;
  logic [LEN_W-1:0]         wr_cnt_d;
  logic                     wr_en_d;
  logic [WR_DATA_W-1:0]     wr_data_d;
  logic                     busy_d, triggered_d, done_d;
  logic                     hist_clr_c, trig_hit_c, write_c, mark_c;

  trig_detect #(.ADC_W(ADC_W)) u_trig_detect (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .hist_clr   (hist_clr_c),
    .adc_valid  (adc_valid),
    .adc_data   (adc_data),
    .trig_level (trig_level),
    .trig_rise  (trig_rise),
    .trig_hit_c (trig_hit_c)
  );

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      decim_q   <= '0;
      dcnt_q    <= '0;
      wr_cnt    <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      busy      <= 1'b0;
      triggered <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      decim_q   <= decim_d;
      dcnt_q    <= dcnt_d;
      wr_cnt    <= wr_cnt_d;
      wr_en     <= wr_en_d;
      wr_data   <= wr_data_d;
      busy      <= busy_d;
      triggered <= triggered_d;
      done      <= done_d;
    end
  end

  // Abort is checked ahead of trigger and write so it always suppresses them.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    decim_d    = decim_q;
    dcnt_d     = dcnt_q;
    wr_cnt_d   = wr_cnt;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data;
    hist_clr_c = 1'b0;
    write_c    = 1'b0;
    mark_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arm && !abort && sdram_init_done && (record_len != '0)) begin
          state_d    = ARMED;
          len_d      = record_len;
          decim_d    = decim;
          wr_cnt_d   = '0;
          hist_clr_c = 1'b1;
        end
      end
      ARMED: begin
        if (abort) begin
          state_d = IDLE;
        end else if (adc_valid && (force_trig || trig_hit_c)) begin
          state_d = CAPTURE;
          dcnt_d  = '0;
          write_c = 1'b1;
          mark_c  = 1'b1;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (adc_valid) begin
          if (dcnt_q == decim_q) begin
            dcnt_d  = '0;
            write_c = 1'b1;
          end else begin
            dcnt_d = dcnt_q + DEC_W'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (write_c) begin
      wr_en_d                  = 1'b1;
      wr_data_d                = WR_DATA_W'(adc_data);
      wr_data_d[TRIG_MARK_BIT] = mark_c;
      wr_cnt_d                 = wr_cnt + LEN_W'(1);
      if (wr_cnt_d == len_q) state_d = DONE;
    end

    busy_d      = (state_d == ARMED) || (state_d == CAPTURE);
    triggered_d = (state_d == CAPTURE);
    done_d      = (state_d == DONE);
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Self-checking bench: directed record scenarios plus random traffic, each
// cycle compared against a behavioural acquisition model.
module tb_adc_capture_ctrl;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned LEN_W = 24;
  localparam int unsigned DEC_W = 8;

  logic             clk_50m = 1'b0;
  logic             rst_n = 1'b0;
  logic             sdram_init_done = 1'b0;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic             force_trig = 1'b0;
  logic [ADC_W-1:0] trig_level = '0;
  logic             trig_rise = 1'b1;
  logic [LEN_W-1:0] record_len = '0;
  logic [DEC_W-1:0] decim = '0;
  logic             adc_valid = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             wr_en;
  logic [15:0]      wr_data;
  logic             busy;
  logic             triggered;
  logic             done;
  logic [LEN_W-1:0] wr_cnt;

  adc_capture_ctrl #(.ADC_W(ADC_W), .LEN_W(LEN_W), .DEC_W(DEC_W)) dut (
    .clk_50m         (clk_50m),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .arm             (arm),
    .abort           (abort),
    .force_trig      (force_trig),
    .trig_level      (trig_level),
    .trig_rise       (trig_rise),
    .record_len      (record_len),
    .decim           (decim),
    .adc_valid       (adc_valid),
    .adc_data        (adc_data),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .busy            (busy),
    .triggered       (triggered),
    .done            (done),
    .wr_cnt          (wr_cnt)
  );

  always #10 clk_50m = ~clk_50m;

  int n_checks = 0;
  int n_errors = 0;
  int src = 0;  // 0 const, 1 ramp up, 2 ramp down, 3 random

  // Behavioural model state: which phase the record is in, plus counters.
  bit          m_armed, m_cap, m_done, m_prev_ok;
  int          m_len, m_dec, m_cnt, m_since, m_prev, m_done_cnt;
  int unsigned m_log[$];
  int unsigned exp_q[$];
  bit          e_wr_en;
  int unsigned e_wr_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic bit crossed(input int prev, input int cur, input int lvl, input bit rise);
    if (rise) return (prev < lvl) && (cur >= lvl);
    return (prev >= lvl) && (cur < lvl);
  endfunction

  function automatic void model_step();
    bit wrote, mark, clr;
    wrote = 0; mark = 0; clr = 0;
    e_wr_en = 0;
    if (!rst_n) begin
      m_armed = 0; m_cap = 0; m_done = 0; m_prev_ok = 0; m_prev = 0;
      m_len = 0; m_dec = 0; m_cnt = 0; m_since = 0; e_wr_data = 0;
      return;
    end
    if (m_done) begin
      m_done = 0;
    end else if (m_armed || m_cap) begin
      if (abort) begin
        m_armed = 0; m_cap = 0;
      end else if (adc_valid) begin
        if (m_armed) begin
          if (force_trig || (m_prev_ok && crossed(m_prev, int'(adc_data), int'(trig_level), trig_rise))) begin
            m_armed = 0; m_cap = 1; m_since = 0; wrote = 1; mark = 1;
          end
        end else begin
          m_since++;
          if (m_since == m_dec + 1) begin
            m_since = 0; wrote = 1;
          end
        end
      end
    end else if (arm && !abort && sdram_init_done && record_len != 0) begin
      m_armed = 1; m_len = int'(record_len); m_dec = int'(decim); m_cnt = 0; clr = 1;
    end
    if (wrote) begin
      e_wr_en = 1;
      e_wr_data = (mark ? 32'h8000 : 32'h0) + int'(adc_data);
      m_log.push_back(e_wr_data);
      m_cnt++;
      if (m_cnt == m_len) begin
        m_cap = 0; m_done = 1; m_done_cnt++;
      end
    end
    if (clr) m_prev_ok = 0;
    else if (adc_valid) begin
      m_prev = int'(adc_data); m_prev_ok = 1;
    end
  endfunction

  // Model advances on each edge; outputs compared once they have settled.
  initial begin
    forever begin
      @(posedge clk_50m);
      model_step();
      #1;
      check("wr_en", wr_en, e_wr_en);
      check("wr_data", wr_data, e_wr_data);
      check("busy", busy, m_armed || m_cap);
      check("triggered", triggered, m_cap);
      check("done", done, m_done);
      check("wr_cnt", wr_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk_50m);
    arm = 1'b0;
    abort = 1'b0;
    case (src)
      1: adc_data = adc_data + 1'b1;
      2: adc_data = adc_data - 1'b1;
      3: begin
        adc_valid = ($urandom_range(0, 3) != 0);
        adc_data  = ADC_W'($urandom_range(0, 4095));
      end
      default: ;
    endcase
  endtask

  task automatic start(input int s, input int d0, input int lvl, input bit rise,
                       input int len, input int dec);
    tick();
    src = s; adc_data = ADC_W'(d0); adc_valid = 1'b1;
    trig_level = ADC_W'(lvl); trig_rise = rise;
    record_len = LEN_W'(len); decim = DEC_W'(dec); force_trig = 1'b0;
    m_log.delete(); m_done_cnt = 0;
    arm = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    check("done_seen", seen, 1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (m_cnt == n) hit = 1;
    end
    check("writes_reached", hit, 1);
  endtask

  task automatic expect_log(input string name);
    check({name, "_len"}, m_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < m_log.size(); i++)
      check(name, m_log[i], exp_q[i]);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    rst_n = 1'b1;
    sdram_init_done = 1'b1;
    tick();

    // Rising ramp, every sample.
    start(1, 90, 100, 1, 8, 0);
    wait_done(60);
    exp_q = '{32'h8064, 32'h65, 32'h66, 32'h67, 32'h68, 32'h69, 32'h6A, 32'h6B};
    expect_log("ramp_d0");
    check("ramp_d0_done_cnt", m_done_cnt, 1);
    repeat (3) tick();
    check("ramp_d0_cnt_hold", wr_cnt, 8);

    // Rising ramp, decimate by 3.
    start(1, 90, 100, 1, 4, 2);
    wait_done(60);
    exp_q = '{32'h8064, 32'h67, 32'h6A, 32'h6D};
    expect_log("ramp_d2");
    check("ramp_d2_done_cnt", m_done_cnt, 1);
    repeat (3) tick();

    // Falling ramp crossing 100.
    start(2, 200, 100, 0, 4, 0);
    wait_done(200);
    exp_q = '{32'h8063, 32'h62, 32'h61, 32'h60};
    expect_log("fall");
    repeat (3) tick();

    // Already below level at arm: no crossing, no write.
    start(0, 50, 100, 0, 4, 0);
    repeat (20) tick();
    check("below_no_write", m_log.size(), 0);
    check("below_busy", busy, 1);
    abort = 1'b1;
    tick();
    check("below_abort_busy", busy, 0);
    tick();

    // Forced trigger on a constant input.
    start(0, 50, 100, 1, 3, 0);
    force_trig = 1'b1;
    wait_done(20);
    force_trig = 1'b0;
    exp_q = '{32'h8032, 32'h32, 32'h32};
    expect_log("force");
    repeat (3) tick();

    // Abort after five writes, then re-arm.
    start(1, 10, 100, 1, 16, 0);
    wait_writes(5, 300);
    abort = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    repeat (5) tick();
    check("abort_writes", m_log.size(), 5);
    check("abort_no_done", m_done_cnt, 0);
    check("abort_cnt", wr_cnt, 5);
    start(1, 90, 100, 1, 8, 0);
    wait_done(60);
    check("rearm_writes", m_log.size(), 8);
    repeat (3) tick();

    // Arms that must be ignored.
    sdram_init_done = 1'b0;
    start(1, 90, 100, 1, 8, 0);
    repeat (10) tick();
    check("noinit_busy", busy, 0);
    sdram_init_done = 1'b1;
    start(1, 90, 100, 1, 0, 0);
    repeat (10) tick();
    check("len0_busy", busy, 0);

    // Reset mid-capture.
    start(1, 90, 100, 1, 16, 0);
    wait_writes(3, 60);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_wr_en", wr_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cnt", wr_cnt, 0);
    repeat (10) tick();
    check("rst_mid_writes", m_log.size(), 3);

    // Random traffic.
    src = 3;
    for (int i = 0; i < 4000; i++) begin
      tick();
      arm             = ($urandom_range(0, 7) == 0);
      abort           = ($urandom_range(0, 39) == 0);
      force_trig      = ($urandom_range(0, 11) == 0);
      sdram_init_done = ($urandom_range(0, 9) != 0);
      record_len      = LEN_W'($urandom_range(0, 6));
      decim           = DEC_W'($urandom_range(0, 3));
      trig_rise       = 1'($urandom_range(0, 1));
      trig_level      = ADC_W'($urandom_range(0, 4095));
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
